// File: rtl/gpu_cmd_queue.sv
// gpu_cmd_queue: host-to-GPU 48-bit command FIFO with a blocking GPU pop and a fence register.
// Define GPU_CMDQ_IRQ_EN to raise irq on fence writes (cleared by the host fence read).
module gpu_cmd_queue #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        host_addr,
  input  logic [31:0]       host_data_i,
  output logic [31:0]       host_data_o,
  input  logic              host_sel,
  input  logic              host_we,
  output logic              host_ready,
  input  logic [1:0]        gpu_addr,
  input  logic [DATA_W-1:0] gpu_data_i,
  output logic [DATA_W-1:0] gpu_data_o,
  input  logic              gpu_sel,
  input  logic              gpu_we,
  output logic              gpu_ready,
  output logic              irq
);
  localparam int CW = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [31:0] stage_lo;
  logic [15:0] fence;
  logic ovf, empty, full, host_wr, push, pop, fence_wr;
  logic unused_ok;
  assign empty = (count == '0);
  assign full = (count == CW'(DEPTH));
  assign host_wr = host_sel & host_we;
  assign push = host_wr & (host_addr == 2'd1) & ~full;
  assign pop = (state == WAIT) & ~empty;
  assign fence_wr = (state == IDLE) & gpu_sel & gpu_we & (gpu_addr == 2'd1);
  assign unused_ok = ^gpu_data_i[DATA_W-1:16];
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= DATA_W'({host_data_i[15:0], stage_lo});
  always_ff @(posedge clk or negedge rst)
    if (!rst) count <= '0;
    else count <= count + CW'(push) - CW'(pop);
  // Host side: every cycle with host_sel is one access, acknowledged the next cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      stage_lo <= '0;
      ovf <= 1'b0;
      host_data_o <= '0;
      host_ready <= 1'b0;
    end else begin
      host_ready <= host_sel;
      if (host_wr && host_addr == 2'd0) stage_lo <= host_data_i;
      if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (host_wr && host_addr == 2'd1 && full) ovf <= 1'b1;
      else if (host_wr && host_addr == 2'd2) ovf <= 1'b0;
      if (host_sel && !host_we)
        host_data_o <= (host_addr == 2'd2) ? {ovf, 15'b0, empty, full, 14'(count)} :
                       (host_addr == 2'd3) ? {16'b0, fence} : 32'b0;
    end
  end
  // GPU side: address-0 reads stall in WAIT until the FIFO holds an entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rd_ptr <= '0;
      gpu_data_o <= '0;
      gpu_ready <= 1'b0;
      fence <= '0;
    end else begin
      case (state)
        IDLE: if (gpu_sel) begin
          if (!gpu_we && gpu_addr == 2'd0) state <= WAIT;
          else begin
            state <= ACK;
            gpu_ready <= 1'b1;
            if (!gpu_we && gpu_addr == 2'd1) gpu_data_o <= DATA_W'(count);
            if (fence_wr) fence <= gpu_data_i[15:0];
          end
        end
        WAIT: if (pop) begin
          gpu_data_o <= mem[rd_ptr];
          rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
          state <= ACK;
          gpu_ready <= 1'b1;
        end
        ACK: begin
          state <= IDLE;
          gpu_ready <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef GPU_CMDQ_IRQ_EN
  // A fence write in the same cycle as the host fence read keeps irq set
  always_ff @(posedge clk or negedge rst)
    if (!rst) irq <= 1'b0;
    else if (fence_wr) irq <= 1'b1;
    else if (host_sel && !host_we && host_addr == 2'd3) irq <= 1'b0;
`else
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_gpu_cmd_queue.sv
// tb_gpu_cmd_queue: randomized scoreboard bench for gpu_cmd_queue against a queue-based model.
module tb_gpu_cmd_queue;
  logic clk = 1'b0, rst = 1'b0;
  logic [1:0] host_addr = '0, gpu_addr = '0;
  logic [31:0] host_data_i = '0, host_data_o;
  logic host_sel = 1'b0, host_we = 1'b0, host_ready;
  logic [47:0] gpu_data_i = '0, gpu_data_o;
  logic gpu_sel = 1'b0, gpu_we = 1'b0, gpu_ready, irq;
  int total = 0, bad = 0;
`ifdef GPU_CMDQ_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  logic [47:0] mq[$];
  logic [31:0] mstage;
  logic movf, mirq;
  logic [15:0] mfence;
  logic [32:0] host_exp[$];
  logic [49:0] gpu_exp[$];

  gpu_cmd_queue dut (
    .clk(clk), .rst(rst),
    .host_addr(host_addr), .host_data_i(host_data_i), .host_data_o(host_data_o),
    .host_sel(host_sel), .host_we(host_we), .host_ready(host_ready),
    .gpu_addr(gpu_addr), .gpu_data_i(gpu_data_i), .gpu_data_o(gpu_data_o),
    .gpu_sel(gpu_sel), .gpu_we(gpu_we), .gpu_ready(gpu_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: responses are compared whenever the DUT acknowledges an access
  always @(negedge clk) begin : mon
    logic [32:0] he;
    logic [49:0] ge;
    if (host_ready) begin
      if (host_exp.size() == 0) check("host_spurious", 64'(host_ready), 64'(0));
      else begin
        he = host_exp.pop_front();
        if (he[32]) check("host_rd", 64'(host_data_o), 64'(he[31:0]));
      end
    end
    if (gpu_ready) begin
      if (gpu_exp.size() == 0) check("gpu_spurious", 64'(gpu_ready), 64'(0));
      else begin
        ge = gpu_exp.pop_front();
        if (ge[49:48] == 2'd2) begin
          if (mq.size() == 0) check("gpu_pop_model_empty", 64'(gpu_data_o), 64'hdead_0000_0000_0000);
          else check("gpu_pop", 64'(gpu_data_o), 64'(mq.pop_front()));
        end else if (ge[49:48] == 2'd1) check("gpu_rd", 64'(gpu_data_o), 64'(ge[47:0]));
      end
    end
  end

  task automatic host_op(input logic [1:0] a, input logic we, input logic [31:0] d);
    logic [32:0] e;
    int n;
    @(negedge clk);
    n = mq.size();
    e = '0;
    if (we) begin
      if (a == 2'd0) mstage = d;
      else if (a == 2'd1) begin
        if (n < 16) mq.push_back({d[15:0], mstage});
        else movf = 1'b1;
      end else if (a == 2'd2) movf = 1'b0;
    end else if (a == 2'd2) e = {1'b1, movf, 15'b0, n == 0, n == 16, 14'(n)};
    else if (a == 2'd3) begin
      e = {1'b1, 16'b0, mfence};
      mirq = 1'b0;
    end
    host_exp.push_back(e);
    host_sel = 1'b1;
    host_addr = a;
    host_we = we;
    host_data_i = d;
    @(negedge clk);
    host_sel = 1'b0;
    check("host_irq", 64'(irq), 64'(IRQ_EN & mirq));
  endtask

  task automatic gpu_op(input logic [1:0] a, input logic we, input logic [47:0] d, output int lat);
    logic [1:0] k;
    @(negedge clk);
    k = 2'd0;
    if (!we && a == 2'd0) k = 2'd2;
    else if (!we && a == 2'd1) k = 2'd1;
    else if (we && a == 2'd1) begin
      mfence = d[15:0];
      mirq = 1'b1;
    end
    gpu_exp.push_back({k, (k == 2'd1) ? 48'(mq.size()) : 48'h0});
    gpu_sel = 1'b1;
    gpu_addr = a;
    gpu_we = we;
    gpu_data_i = d;
    @(negedge clk);
    gpu_sel = 1'b0;
    lat = 1;
    while (!gpu_ready && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!gpu_ready) check("gpu_timeout", 64'(gpu_ready), 64'(1));
    check("gpu_irq", 64'(irq), 64'(IRQ_EN & mirq));
  endtask

  initial begin
    int lat, r;
    logic [1:0] a;
    logic we;
    mstage = '0;
    movf = 1'b0;
    mfence = '0;
    mirq = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_host_ready", 64'(host_ready), 64'(0));
    check("rst_gpu_ready", 64'(gpu_ready), 64'(0));
    check("rst_irq", 64'(irq), 64'(0));
    check("rst_host_data", 64'(host_data_o), 64'(0));
    check("rst_gpu_data", 64'(gpu_data_o), 64'(0));
    host_op(2'd2, 1'b0, 32'h0);
    // Single push and pop
    host_op(2'd0, 1'b1, 32'h89AB_CDEF);
    host_op(2'd1, 1'b1, 32'h0000_4567);
    gpu_op(2'd0, 1'b0, 48'h0, lat);
    check("pop_lat", 64'(lat), 64'(2));
    host_op(2'd2, 1'b0, 32'h0);
    // Pop on empty FIFO stalls until the host pushes
    fork
      begin
        gpu_op(2'd0, 1'b0, 48'h0, lat);
        check("stall_lat", 64'(lat), 64'(14));
      end
      begin
        repeat (10) begin
          @(negedge clk);
          check("stall_hold", 64'(gpu_ready), 64'(0));
        end
        host_op(2'd0, 1'b1, 32'h0000_0001);
        host_op(2'd1, 1'b1, 32'h0000_0000);
        check("stall_early", 64'(gpu_ready), 64'(0));
        @(negedge clk);
        check("stall_wake", 64'(gpu_ready), 64'(1));
      end
    join
    // Overflow: seventeenth push is dropped
    for (int i = 0; i < 17; i++) begin
      host_op(2'd0, 1'b1, $urandom);
      host_op(2'd1, 1'b1, $urandom);
    end
    host_op(2'd2, 1'b0, 32'h0);
    for (int i = 0; i < 16; i++) begin
      gpu_op(2'd0, 1'b0, 48'h0, lat);
      check("ovf_pop_lat", 64'(lat), 64'(2));
    end
    host_op(2'd2, 1'b0, 32'h0);
    host_op(2'd2, 1'b1, 32'h0);
    host_op(2'd2, 1'b0, 32'h0);
    // Eight resident entries with push and pop on the same edge
    for (int i = 0; i < 8; i++) begin
      host_op(2'd0, 1'b1, $urandom);
      host_op(2'd1, 1'b1, $urandom);
    end
    for (int i = 0; i < 40; i++) begin
      fork
        begin
          host_op(2'd0, 1'b1, $urandom);
          host_op(2'd1, 1'b1, $urandom);
        end
        begin
          @(negedge clk);
          gpu_op(2'd0, 1'b0, 48'h0, lat);
        end
      join
      check("steady_lat", 64'(lat), 64'(2));
    end
    host_op(2'd2, 1'b0, 32'h0);
    gpu_op(2'd1, 1'b0, 48'h0, lat);
    // Fence write and host fence read
    gpu_op(2'd1, 1'b1, 48'h00_BEEF, lat);
    host_op(2'd3, 1'b0, 32'h0);
    // Random mix of accesses
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 7));
      if (r < 2) host_op(2'd0, 1'b1, $urandom);
      else if (r < 4) host_op(2'd1, 1'b1, $urandom);
      else if (r == 4) host_op(2'd2, 1'($urandom_range(0, 1)), $urandom);
      else if (r == 5) host_op(2'd3, 1'b0, $urandom);
      else if (r == 6 && mq.size() > 0) begin
        gpu_op(2'd0, 1'b0, 48'h0, lat);
        check("rnd_pop_lat", 64'(lat), 64'(2));
      end else begin
        a = 2'($urandom_range(0, 3));
        we = (a == 2'd0) ? 1'b1 : 1'($urandom_range(0, 1));
        gpu_op(a, we, 48'({$urandom, $urandom}), lat);
        check("rnd_gpu_lat", 64'(lat), 64'(1));
      end
    end
    // Reset with entries and a fence pending
    host_op(2'd0, 1'b1, $urandom);
    host_op(2'd1, 1'b1, $urandom);
    gpu_op(2'd1, 1'b1, 48'h00_1234, lat);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mq.delete();
    mstage = '0;
    movf = 1'b0;
    mfence = '0;
    mirq = 1'b0;
    check("rst2_irq", 64'(irq), 64'(0));
    host_op(2'd2, 1'b0, 32'h0);
    host_op(2'd3, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    check("host_exp_left", 64'(host_exp.size()), 64'(0));
    check("gpu_exp_left", 64'(gpu_exp.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
